// File: rtl/tx_word_sequencer.sv
// Hands a loaded 128-bit block to a downstream sink as NUM_WORDS 32-bit words
// by strobing load/shift on an external shift register, with backpressure and flush.
module tx_word_sequencer #(
    parameter int NUM_WORDS = 4
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       block_valid,
    output logic       block_ready,
    output logic       word_valid,
    input  logic       word_ready,
    output logic       word_last,
    output logic [1:0] word_idx,
    input  logic       flush,
    output logic       load_enable,
    output logic       shift_enable,
    output logic       block_done,
    output logic [7:0] block_count,
    output logic       busy
);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);

    state_t     state_q, state_d;
    logic [1:0] word_idx_q, word_idx_d;
    logic       block_done_q, block_done_d;
    logic [7:0] block_count_q, block_count_d;

    logic in_send;
    logic is_last;
    logic word_acc;
    logic block_acc;

    // Handshake outputs are combinational and forced low while reset is held.
    always_comb begin
        in_send      = n_rst && (state_q == SEND);
        is_last      = (word_idx_q == LAST_IDX);
        word_valid   = in_send && !flush;
        word_last    = word_valid && is_last;
        word_acc     = word_valid && word_ready;
        block_ready  = n_rst && !flush && (!in_send || (word_last && word_ready));
        block_acc    = block_valid && block_ready;
        load_enable  = block_acc;
        shift_enable = word_acc && !is_last;
        busy         = in_send;
        word_idx     = n_rst ? word_idx_q : 2'd0;
        block_done   = n_rst && block_done_q;
        block_count  = n_rst ? block_count_q : 8'd0;
    end

    always_comb begin
        state_d       = state_q;
        word_idx_d    = word_idx_q;
        block_done_d  = word_acc && is_last;
        block_count_d = block_count_q + {7'd0, block_done_d};

        // A reload on the last word wins over returning to IDLE (no bubble).
        if (flush) begin
            state_d    = IDLE;
            word_idx_d = 2'd0;
        end else if (block_acc) begin
            state_d    = SEND;
            word_idx_d = 2'd0;
        end else if (word_acc) begin
            if (is_last) begin
                state_d    = IDLE;
                word_idx_d = 2'd0;
            end else begin
                word_idx_d = word_idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            word_idx_q    <= 2'd0;
            block_done_q  <= 1'b0;
            block_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            word_idx_q    <= word_idx_d;
            block_done_q  <= block_done_d;
            block_count_q <= block_count_d;
        end
    end

endmodule

// File: tb/tb_tx_word_sequencer.sv
// Scoreboard bench for tx_word_sequencer: directed stimulus pushes expected
// words/completions; a negedge monitor pops and compares on every handshake.
module tb_tx_word_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst, block_valid, word_ready, flush;
    logic       block_ready, word_valid, word_last, load_enable, shift_enable;
    logic       block_done, busy;
    logic [1:0] word_idx;
    logic [7:0] block_count;

    logic       b_valid, b_wready, b_flush;
    logic       b_bready, b_wvalid, b_wlast, b_load, b_shift, b_done, b_busy;
    logic [1:0] b_idx;
    logic [7:0] b_count;

    tx_word_sequencer #(.NUM_WORDS(4)) u0 (
        .clk(clk), .n_rst(n_rst), .block_valid(block_valid), .block_ready(block_ready),
        .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
        .word_idx(word_idx), .flush(flush), .load_enable(load_enable),
        .shift_enable(shift_enable), .block_done(block_done),
        .block_count(block_count), .busy(busy)
    );

    tx_word_sequencer #(.NUM_WORDS(1)) u1 (
        .clk(clk), .n_rst(n_rst), .block_valid(b_valid), .block_ready(b_bready),
        .word_valid(b_wvalid), .word_ready(b_wready), .word_last(b_wlast),
        .word_idx(b_idx), .flush(b_flush), .load_enable(b_load),
        .shift_enable(b_shift), .block_done(b_done),
        .block_count(b_count), .busy(b_busy)
    );

    typedef struct packed {
        logic [1:0] idx;
        logic       last;
    } word_exp_t;

    word_exp_t word_q[$];
    int        done_q[$];
    word_exp_t mon_e;
    int        n_pass = 0;
    int        n_total = 0;
    int        exp_count = 0;
    bit        mon_en = 1'b0;

    int t3_idx[7]   = '{0, 0, 1, 1, 1, 2, 3};
    int t3_shift[7] = '{0, 1, 0, 0, 1, 1, 0};

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int n, input bit full);
        word_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx  = 2'(i);
            e.last = full && (i == n - 1);
            word_q.push_back(e);
        end
        if (full) begin
            exp_count = (exp_count + 1) % 256;
            done_q.push_back(exp_count);
        end
    endtask

    // Back-to-back blocks: hold block_valid until n loads are seen, then drain.
    task automatic run_blocks(input int n);
        int loads = 0;
        int guard = 0;
        for (int i = 0; i < n; i++) push_words(4, 1'b1);
        block_valid = 1'b1;
        while (loads < n && guard < 8 * n + 8) begin
            #1;
            if (load_enable) loads++;
            step();
            if (loads == n) block_valid = 1'b0;
            guard++;
        end
        check("run_loads", loads, n);
        block_valid = 1'b0;
        guard = 0;
        #1;
        while (busy && guard < 16) begin
            step();
            guard++;
        end
        check("run_idle", busy, 0);
        step();
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_excl", int'(load_enable && shift_enable), 0);
            if (word_valid && word_ready) begin
                if (word_q.size() == 0) check("word_unexpected", 1, 0);
                else begin
                    mon_e = word_q.pop_front();
                    check("sb_word_idx", word_idx, mon_e.idx);
                    check("sb_word_last", word_last, mon_e.last);
                    check("sb_shift", shift_enable, !mon_e.last);
                end
            end else begin
                check("shift_no_accept", shift_enable, 0);
            end
            if (block_done) begin
                if (done_q.size() == 0) check("done_unexpected", 1, 0);
                else check("sb_block_count", block_count, done_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_rst = 1'b0; block_valid = 1'b1; word_ready = 1'b1; flush = 1'b0;
        b_valid = 1'b0; b_wready = 1'b1; b_flush = 1'b0;

        // Reset: everything low even with block_valid asserted
        repeat (3) step();
        #1;
        check("rst_block_ready", block_ready, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_word_last", word_last, 0);
        check("rst_load", load_enable, 0);
        check("rst_shift", shift_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_done", block_done, 0);
        check("rst_count", block_count, 0);
        check("rst_idx", word_idx, 0);
        mon_en = 1'b1;

        // Single block; acceptance in first cycle out of reset
        step();
        push_words(4, 1'b1);
        n_rst = 1'b1;
        #1;
        check("t1_load", load_enable, 1);
        check("t1_valid_c0", word_valid, 0);
        step();
        block_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("t1_word_valid", word_valid, 1);
            check("t1_word_idx", word_idx, c - 1);
            check("t1_shift", shift_enable, int'(c < 4));
            check("t1_last", word_last, int'(c == 4));
            check("t1_load_off", load_enable, 0);
            step();
        end
        #1;
        check("t1_done", block_done, 1);
        check("t1_count", block_count, 1);
        check("t1_busy", busy, 0);

        // Back-to-back with block_valid held
        step();
        push_words(4, 1'b1);
        push_words(4, 1'b1);
        block_valid = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            if (c == 5) block_valid = 1'b0;
            #1;
            check("t2_load", load_enable, int'(c == 0 || c == 4));
            check("t2_word_valid", word_valid, int'(c >= 1 && c <= 8));
            check("t2_done", block_done, int'(c == 5 || c == 9));
            if (c == 9) check("t2_count", block_count, 3);
            step();
        end

        // Backpressure on cycles 2-3
        push_words(4, 1'b1);
        block_valid = 1'b1;
        for (int c = 0; c <= 7; c++) begin
            if (c == 1) block_valid = 1'b0;
            word_ready = !(c == 2 || c == 3);
            #1;
            if (c >= 1 && c <= 6) begin
                check("t3_idx", word_idx, t3_idx[c]);
                check("t3_shift", shift_enable, t3_shift[c]);
            end
            check("t3_done", block_done, int'(c == 7));
            step();
        end
        word_ready = 1'b1;

        // Flush while idle blocks acceptance
        flush = 1'b1;
        block_valid = 1'b1;
        #1;
        check("t4_idle_flush_ready", block_ready, 0);
        check("t4_idle_flush_load", load_enable, 0);
        step();
        flush = 1'b0;
        block_valid = 1'b0;
        #1;
        check("t4_idle_flush_busy", busy, 0);
        step();

        // Flush at word_idx 2, then immediate new block
        push_words(2, 1'b0);
        push_words(4, 1'b1);
        block_valid = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            if (c == 1) block_valid = 1'b0;
            if (c == 4) block_valid = 1'b1;
            flush = (c == 3);
            #1;
            if (c == 3) begin
                check("t4_flush_idx", word_idx, 2);
                check("t4_flush_valid", word_valid, 0);
                check("t4_flush_shift", shift_enable, 0);
                check("t4_flush_ready", block_ready, 0);
            end
            if (c == 4) begin
                check("t4_after_busy", busy, 0);
                check("t4_after_idx", word_idx, 0);
                check("t4_after_load", load_enable, 1);
                check("t4_after_done", block_done, 0);
                check("t4_after_count", block_count, 4);
            end
            step();
        end
        block_valid = 1'b0;
        repeat (5) step();

        // Reset mid-block at word_idx 1
        push_words(1, 1'b0);
        block_valid = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            if (c == 1) block_valid = 1'b0;
            n_rst = !(c == 2 || c == 3);
            #1;
            if (c == 2) begin
                check("t5_rst_valid", word_valid, 0);
                check("t5_rst_last", word_last, 0);
                check("t5_rst_ready", block_ready, 0);
                check("t5_rst_busy", busy, 0);
                check("t5_rst_shift", shift_enable, 0);
            end
            if (c == 3) begin
                check("t5_rst_count", block_count, 0);
                check("t5_rst_done", block_done, 0);
                check("t5_rst_idx", word_idx, 0);
            end
            step();
        end
        n_rst = 1'b1;
        exp_count = 0;
        #1;
        check("t5_release_ready", block_ready, 1);
        run_blocks(1);

        // Count wraps after 256 completions
        run_blocks(255);
        #1;
        check("t6_wrap_count", block_count, 0);

        // NUM_WORDS=1 instance: every word is last, never a shift
        step();
        b_valid = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            if (c == 3) b_valid = 1'b0;
            #1;
            check("t7_load", b_load, int'(c <= 2));
            check("t7_word_valid", b_wvalid, int'(c >= 1 && c <= 3));
            check("t7_last", b_wlast, int'(c >= 1 && c <= 3));
            check("t7_shift", b_shift, 0);
            check("t7_done", b_done, int'(c >= 2));
            if (c == 4) check("t7_count", b_count, 3);
            step();
        end

        check("sb_words_left", word_q.size(), 0);
        check("sb_done_left", done_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
